// File: rtl/bus_timer_if.sv
// CPU bus interface: a single master drives requests, the responder (modport s)
// acknowledges with a one-cycle ready pulse and may raise a level interrupt.
interface Bus;
    logic        clk;
    logic        reset;
    logic        valid;
    logic [31:0] address;
    logic [3:0]  wstrobe;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;
    logic        irq;

    modport s (
        input  clk, reset, valid, address, wstrobe, wdata,
        output ready, rdata, irq
    );

    modport m (
        input  clk, reset, ready, rdata, irq,
        output valid, address, wstrobe, wdata
    );
endinterface

// File: rtl/bus_timer.sv
// Memory-mapped timer peripheral. A prescaler divides the clock into count ticks;
// COUNT climbs to LIMIT, wraps to zero and latches PEND, which raises irq when IE=1.
// Register map (address[3:2]): 0 LIMIT, 1 COUNT, 2 CONTROL {PEND,IE,EN}, 3 reserved.
module bus_timer #(
    parameter int unsigned PRESCALE = 1
) (
    Bus.s bus
);

    localparam logic [16:0] PRE_MAX = 17'(PRESCALE - 32'd1);

    // Merge write data into an existing word, one byte per strobe bit.
    function automatic logic [31:0] f_byte_merge(input logic [31:0] i_old,
                                                 input logic [31:0] i_new,
                                                 input logic [3:0]  i_strb);
        logic [31:0] v;
        v = i_old;
        for (int b = 0; b < 4; b++) begin
            if (i_strb[b]) begin
                v[b*8 +: 8] = i_new[b*8 +: 8];
            end else begin
                v[b*8 +: 8] = i_old[b*8 +: 8];
            end
        end
        return v;
    endfunction

    logic [31:0] r_limit;
    logic [31:0] r_count;
    logic [16:0] r_pre;
    logic        r_en;
    logic        r_ie;
    logic        r_pend;
    logic        r_ready;
    logic [31:0] r_rdata;
    logic        r_irq;

    logic [31:0] w_limit_nx;
    logic [31:0] w_count_nx;
    logic [16:0] w_pre_nx;
    logic        w_en_nx;
    logic        w_ie_nx;
    logic        w_pend_nx;
    logic [31:0] w_rdata_nx;

    logic        w_accept;
    logic        w_write;
    logic [1:0]  w_sel;
    logic        w_limit_wr;
    logic        w_count_wr;
    logic        w_ctrl_wr;
    logic        w_tick;
    logic        w_match;
    logic        w_wrap;
    logic        w_unused_addr;

    // A request is taken only while no acknowledge is outstanding, so every
    // transaction occupies two cycles even when valid is held high.
    assign w_accept   = bus.valid & ~r_ready;
    assign w_sel      = bus.address[3:2];
    assign w_write    = w_accept & (bus.wstrobe != 4'b0000);
    assign w_limit_wr = w_write & (w_sel == 2'd0);
    assign w_count_wr = w_write & (w_sel == 2'd1);
    assign w_ctrl_wr  = w_write & (w_sel == 2'd2) & bus.wstrobe[0];
    assign w_tick     = r_en & (r_pre == PRE_MAX);
    assign w_match    = (r_count == r_limit);
    // A bus write to COUNT overrides the tick, so that tick cannot wrap or set PEND.
    assign w_wrap     = w_tick & w_match & ~w_count_wr;

    assign w_unused_addr = ^{bus.address[31:4], bus.address[1:0]};

    // Prescaler advances only while enabled and restarts at zero after each tick.
    always_comb begin
        w_pre_nx = r_pre;
        if (r_en) begin
            if (r_pre == PRE_MAX) begin
                w_pre_nx = 17'd0;
            end else begin
                w_pre_nx = r_pre + 17'd1;
            end
        end else begin
            w_pre_nx = r_pre;
        end
    end

    // Next LIMIT/COUNT: bus write beats the tick; a tick wraps on match, else increments.
    always_comb begin
        w_limit_nx = r_limit;
        w_count_nx = r_count;
        if (w_limit_wr) begin
            w_limit_nx = f_byte_merge(r_limit, bus.wdata, bus.wstrobe);
        end else begin
            w_limit_nx = r_limit;
        end
        if (w_count_wr) begin
            w_count_nx = f_byte_merge(r_count, bus.wdata, bus.wstrobe);
        end else if (w_tick) begin
            if (w_match) begin
                w_count_nx = 32'd0;
            end else begin
                w_count_nx = r_count + 32'd1;
            end
        end else begin
            w_count_nx = r_count;
        end
    end

    // Next CONTROL bits: PEND is write-1-to-clear, and a same-edge wrap keeps it set.
    always_comb begin
        w_en_nx   = r_en;
        w_ie_nx   = r_ie;
        w_pend_nx = r_pend;
        if (w_ctrl_wr) begin
            w_en_nx = bus.wdata[0];
            w_ie_nx = bus.wdata[1];
        end else begin
            w_en_nx = r_en;
            w_ie_nx = r_ie;
        end
        if (w_wrap) begin
            w_pend_nx = 1'b1;
        end else if (w_ctrl_wr && bus.wdata[2]) begin
            w_pend_nx = 1'b0;
        end else begin
            w_pend_nx = r_pend;
        end
    end

    // Read data is taken from the current register values, before this edge's updates.
    always_comb begin
        w_rdata_nx = 32'd0;
        if (w_accept) begin
            case (w_sel)
                2'd0:    w_rdata_nx = r_limit;
                2'd1:    w_rdata_nx = r_count;
                2'd2:    w_rdata_nx = {29'd0, r_pend, r_ie, r_en};
                default: w_rdata_nx = 32'd0;
            endcase
        end else begin
            w_rdata_nx = 32'd0;
        end
    end

    // State and output registers; reset drops any transaction in flight.
    always_ff @(posedge bus.clk) begin
        if (bus.reset) begin
            r_limit <= 32'd0;
            r_count <= 32'd0;
            r_pre   <= 17'd0;
            r_en    <= 1'b0;
            r_ie    <= 1'b0;
            r_pend  <= 1'b0;
            r_ready <= 1'b0;
            r_rdata <= 32'd0;
            r_irq   <= 1'b0;
        end else begin
            r_limit <= w_limit_nx;
            r_count <= w_count_nx;
            r_pre   <= w_pre_nx;
            r_en    <= w_en_nx;
            r_ie    <= w_ie_nx;
            r_pend  <= w_pend_nx;
            r_ready <= w_accept;
            r_rdata <= w_rdata_nx;
            r_irq   <= w_pend_nx & w_ie_nx;
        end
    end

    assign bus.ready = r_ready;
    assign bus.rdata = r_rdata;
    assign bus.irq   = r_irq;

endmodule
